// File: rtl/cpu_memory_stage.sv
// Memory stage: turns each newly tagged execute result into a bus load/store/flush and a writeback record.
// Latency: 1 cycle for non-memory ops, 2+ cycles for bus ops; o_busy stalls execute while a bus op is pending or after a fault.
module cpu_memory_stage #(
  parameter int TAG_WIDTH = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic [4:0]           i_inst_rd,
  input  logic [31:0]          i_rd,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic                 i_mem_flush,
  input  logic [1:0]           i_mem_width,
  input  logic                 i_mem_signed,
  input  logic [31:0]          i_mem_address,
  input  logic [4:0]           i_mem_inst_rd,
  output logic                 o_busy,
  output logic                 o_bus_request,
  output logic                 o_bus_rw,
  output logic                 o_bus_flush,
  output logic [31:0]          o_bus_address,
  output logic [3:0]           o_bus_byte_enable,
  output logic [31:0]          o_bus_wdata,
  input  logic                 i_bus_ready,
  input  logic [31:0]          i_bus_rdata,
  output logic                 o_fault,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic [4:0]           o_inst_rd,
  output logic [31:0]          o_rd
);

  typedef enum logic [1:0] {IDLE, BUS_WAIT, FAULT} state_t;

  state_t state, state_nxt;

  logic                 cap_load;
  logic                 cap_signed;
  logic [1:0]           cap_width;
  logic [1:0]           cap_off;
  logic [4:0]           cap_rd;
  logic [TAG_WIDTH-1:0] cap_tag;

  logic        tag_new;
  logic        mem_op;
  logic        misaligned;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] lane;
  logic [31:0] load_val;

  // o_tag always equals the last accepted tag whenever the FSM is in IDLE
  assign tag_new    = (i_tag != o_tag);
  assign mem_op     = i_mem_read | i_mem_write | i_mem_flush;
  assign misaligned = (i_mem_width == 2'd3) ||
                      (i_mem_width == 2'd1 && i_mem_address[0]) ||
                      (i_mem_width == 2'd2 && i_mem_address[1:0] != 2'b00);

  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    case (state)
      IDLE: begin
        if (tag_new && mem_op) begin
          o_busy    = 1'b1;
          state_nxt = misaligned ? FAULT : BUS_WAIT;
        end
      end
      BUS_WAIT: begin
        o_busy = 1'b1;
        if (i_bus_ready) state_nxt = IDLE;
      end
      default: o_busy = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = i_rd;
    case (i_mem_width)
      2'd0: begin
        be_nxt    = 4'b0001 << i_mem_address[1:0];
        wdata_nxt = {4{i_rd[7:0]}};
      end
      2'd1: begin
        be_nxt    = 4'b0011 << i_mem_address[1:0];
        wdata_nxt = {2{i_rd[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane     = i_bus_rdata >> {cap_off, 3'b000};
    load_val = lane;
    case (cap_width)
      2'd0:    load_val = {{24{cap_signed & lane[7]}}, lane[7:0]};
      2'd1:    load_val = {{16{cap_signed & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_bus_request     <= 1'b0;
      o_bus_rw          <= 1'b0;
      o_bus_flush       <= 1'b0;
      o_bus_address     <= '0;
      o_bus_byte_enable <= '0;
      o_bus_wdata       <= '0;
      o_fault           <= 1'b0;
      o_tag             <= '0;
      o_inst_rd         <= '0;
      o_rd              <= '0;
      cap_load          <= 1'b0;
      cap_signed        <= 1'b0;
      cap_width         <= '0;
      cap_off           <= '0;
      cap_rd            <= '0;
      cap_tag           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tag_new && !mem_op) begin
            o_tag     <= i_tag;
            o_inst_rd <= i_inst_rd;
            o_rd      <= i_rd;
          end else if (tag_new && misaligned) begin
            o_fault <= 1'b1;
          end else if (tag_new) begin
            cap_load          <= i_mem_read;
            cap_signed        <= i_mem_signed;
            cap_width         <= i_mem_width;
            cap_off           <= i_mem_address[1:0];
            cap_rd            <= i_mem_inst_rd;
            cap_tag           <= i_tag;
            o_bus_request     <= 1'b1;
            o_bus_rw          <= i_mem_write;
            o_bus_flush       <= i_mem_flush;
            o_bus_address     <= {i_mem_address[31:2], 2'b00};
            o_bus_byte_enable <= i_mem_flush ? 4'b0000 : be_nxt;
            o_bus_wdata       <= i_mem_write ? wdata_nxt : 32'h0;
          end
        end
        BUS_WAIT: begin
          if (i_bus_ready) begin
            o_bus_request     <= 1'b0;
            o_bus_rw          <= 1'b0;
            o_bus_flush       <= 1'b0;
            o_bus_address     <= '0;
            o_bus_byte_enable <= '0;
            o_bus_wdata       <= '0;
            o_tag             <= cap_tag;
            if (cap_load) begin
              o_rd      <= load_val;
              o_inst_rd <= cap_rd;
            end else begin
              o_inst_rd <= 5'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
